// File: rtl/key_schedule_iter.sv
// Iterative AES-128 key expansion. Accepts one cipher key, then streams round keys 0..10
// through a valid/ready handshake. A single SubWord/RotWord/Rcon datapath serves every round.
module key_schedule_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key,
  output logic         key_ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);

  // Word c sits at [127-32c -: 32]; byte r of a word sits at [31-8r -: 8].
  localparam logic [3:0] LastIdx = 4'd10;

  // FIPS-197 S-box; row = high nibble, column = low nibble.
  localparam logic [0:15][0:15][7:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[b[7:4]][b[3:0]];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_e       state_q, state_d;
  logic [127:0] cur_q, cur_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic [7:0]   rcon_next;

  // Next round key, combinational from cur_q: one S-box level plus the XOR chain.
  always_comb begin
    w0       = cur_q[127:96];
    w1       = cur_q[95:64];
    w2       = cur_q[63:32];
    w3       = cur_q[31:0];
    t_word   = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h000000};
    n0       = w0 ^ t_word;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    case (state_q)
      StIdle: begin
        if (key_valid) begin
          cur_d   = key;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = StRun;
        end
      end
      StRun: begin
        if (rk_ready) begin
          // The final round only releases the block; round state is left as is.
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            cur_d  = next_key;
            idx_d  = idx_q + 4'd1;
            rcon_d = rcon_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  assign key_ready = (state_q == StIdle);
  assign rk_valid  = (state_q == StRun);
  assign rk        = cur_q;
  assign rk_idx    = idx_q;
  assign rk_last   = (idx_q == LastIdx);

endmodule

// File: tb/tb_key_schedule_iter.sv
// Scoreboard bench for key_schedule_iter: expected round keys are queued at issue time and
// a monitor compares every output handshake; directed tasks check cycle timing and reset.
module tb_key_schedule_iter;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic [127:0] key;
  logic         key_ready;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_last;

  key_schedule_iter dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key       (key),
    .key_ready (key_ready),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk        (rk),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZeroKey = 128'h0;

  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  typedef struct packed {
    logic [127:0] rk;
    logic [3:0]   idx;
    logic         chk_rk;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_fips();
    for (int k = 0; k < 11; k++) sb_q.push_back('{fips_rk[k], 4'(k), 1'b1});
  endtask

  // Only the rounds with published values are compared by content.
  task automatic push_zero();
    for (int k = 0; k < 11; k++) begin
      if (k == 0)       sb_q.push_back('{128'h0, 4'(k), 1'b1});
      else if (k == 1)  sb_q.push_back('{128'h62636363626363636263636362636363, 4'(k), 1'b1});
      else if (k == 10) sb_q.push_back('{128'hb4ef5bcb3e92e21123e951cf6f8f188e, 4'(k), 1'b1});
      else              sb_q.push_back('{128'h0, 4'(k), 1'b0});
    end
  endtask

  // Monitor: pops on every handshake, and checks output stability across stalls.
  initial begin
    logic         stall_v;
    logic [127:0] hold_rk;
    logic [3:0]   hold_idx;
    exp_t         e;
    stall_v = 1'b0;
    hold_rk = '0;
    hold_idx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_v = 1'b0;
      end else begin
        if (stall_v && rk_valid) begin
          chk("stall_rk", rk, hold_rk);
          chk("stall_idx", 128'(rk_idx), 128'(hold_idx));
        end
        if (rk_valid && rk_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rk: got idx %0d rk %h expected none", rk_idx, rk);
          end else begin
            e = sb_q.pop_front();
            chk("rk_idx", 128'(rk_idx), 128'(e.idx));
            chk("rk_last", 128'(rk_last), 128'(e.idx == 4'd10));
            if (e.chk_rk) chk("rk_value", rk, e.rk);
          end
        end
        stall_v  = rk_valid && !rk_ready;
        hold_rk  = rk;
        hold_idx = rk_idx;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key_ready"}, 128'(key_ready), 128'(1'b1));
    chk({tag, "_rk_valid"}, 128'(rk_valid), 128'(1'b0));
    chk({tag, "_rk"}, rk, 128'h0);
    chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(4'd0));
    chk({tag, "_rk_last"}, 128'(rk_last), 128'(1'b0));
  endtask

  // Called at posedge+1 with the block idle; presents k for exactly one cycle.
  task automatic send_key(input logic [127:0] k);
    key       = k;
    key_valid = 1'b1;
    @(negedge clk);
    chk("accept_ready", 128'(key_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  // With rk_ready held high: round k in cycle T+1+k, key_ready back in T+12.
  task automatic check_nostall_timing();
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk("run_valid", 128'(rk_valid), 128'(1'b1));
      chk("run_idx", 128'(rk_idx), 128'(k));
    end
    @(negedge clk);
    chk("done_key_ready", 128'(key_ready), 128'(1'b1));
    chk("done_rk_valid", 128'(rk_valid), 128'(1'b0));
  endtask

  task automatic wait_idx(input int target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rk_valid && rk_idx == 4'(target)) && n < 60);
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL wait_idx: got timeout expected idx %0d", target);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat;
    int          n;
    pat       = 32'b1011_0010_0111_0001_1100_1010_0110_1101;
    rst       = 1'b1;
    key_valid = 1'b1;       // must not be latched during reset
    key       = FipsKey;
    rk_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    key_valid = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // FIPS key, no backpressure.
    @(posedge clk);
    #1;
    push_fips();
    send_key(FipsKey);
    check_nostall_timing();

    // FIPS key with pseudo-random backpressure.
    @(posedge clk);
    #1;
    rk_ready = 1'b0;
    push_fips();
    send_key(FipsKey);
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      rk_ready = pat[n % 32];
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL stall_drain: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
    rk_ready = 1'b1;
    @(negedge clk);
    chk("stall_done_valid", 128'(rk_valid), 128'(1'b0));

    // All-zero key.
    @(posedge clk);
    #1;
    push_zero();
    send_key(ZeroKey);
    check_nostall_timing();

    // key_valid pulsed with another key at round 4 is ignored.
    @(posedge clk);
    #1;
    push_fips();
    send_key(FipsKey);
    wait_idx(4);
    @(posedge clk);
    #1;
    key       = ZeroKey;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    wait_drain();
    repeat (3) begin
      @(negedge clk);
      chk("no_capture_valid", 128'(rk_valid), 128'(1'b0));
    end

    // Reset at round 6, then a new key right after reset deasserts.
    @(posedge clk);
    #1;
    push_fips();
    send_key(FipsKey);
    wait_idx(6);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    key       = ZeroKey;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    push_fips();
    key       = FipsKey;
    key_valid = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    check_nostall_timing();

    // Back-to-back keys with key_valid held high.
    @(posedge clk);
    #1;
    push_fips();
    push_zero();
    key       = FipsKey;
    key_valid = 1'b1;
    @(negedge clk);
    chk("b2b_first_ready", 128'(key_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    key = ZeroKey;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk("b2b_idx", 128'(rk_idx), 128'(k));
      chk("b2b_busy", 128'(key_ready), 128'(1'b0));
    end
    @(negedge clk);
    chk("b2b_second_ready", 128'(key_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    @(negedge clk);
    chk("b2b_r0_valid", 128'(rk_valid), 128'(1'b1));
    chk("b2b_r0_idx", 128'(rk_idx), 128'(4'd0));
    chk("b2b_r0_rk", rk, ZeroKey);
    wait_drain();
    @(negedge clk);
    chk("b2b_done_valid", 128'(rk_valid), 128'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
